// File: rtl/gpio_intc_pkg.sv
// Shared register offsets and bus word type for the GPIO interrupt controller.
package gpio_intc_pkg;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] GPIO_DATA = 3'd0;
  localparam logic [ADDR_W-1:0] GPIO_EN   = 3'd1;
  localparam logic [ADDR_W-1:0] GPIO_RISE = 3'd2;
  localparam logic [ADDR_W-1:0] GPIO_FALL = 3'd3;
  localparam logic [ADDR_W-1:0] GPIO_PEND = 3'd4;
  localparam logic [ADDR_W-1:0] GPIO_STAT = 3'd5;

  typedef logic [31:0] reg_word_t;
endpackage

// File: rtl/gpio_debounce.sv
// Single-channel input conditioner: synchroniser chain, plus a stability
// counter when GPIO_INTC_DEBOUNCE_EN is defined.
module gpio_debounce
  import gpio_intc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_deb
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_INTC_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;

  // The counter only runs while the synchronised pin disagrees with the
  // accepted state, so any return to agreement restarts qualification.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (w_sync != r_deb) begin
      if (r_cnt == CNT_LAST) begin
        r_deb <= w_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_deb = r_deb;
`else
  assign o_deb = w_sync;
`endif
endmodule

// File: rtl/gpio_intc.sv
// GPIO input and interrupt controller: per-channel edge select, sticky
// pending, masked level irq and a single-cycle req/ack register port.
// Optional debounce counters are built when GPIO_INTC_DEBOUNCE_EN is defined.
module gpio_intc
  import gpio_intc_pkg::*;
#(
  parameter int NCH             = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    gpio_in,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              irq
);
  logic [NCH-1:0] w_deb;
  logic [NCH-1:0] w_set;
  logic [NCH-1:0] w_clr;
  logic           w_wr;
  reg_word_t      w_rd;

  logic [NCH-1:0] r_deb_q;
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_rise;
  logic [NCH-1:0] r_fall;
  logic [NCH-1:0] r_pend;
  reg_word_t      r_rdata;
  logic           r_ack;
  logic           r_irq;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .i_pin(gpio_in[g]),
      .o_deb(w_deb[g])
    );
  end

  if (NCH < 32) begin : g_unused
    logic w_unused;
    assign w_unused = ^wdata[31:NCH];
  end

  function automatic reg_word_t zext(input logic [NCH-1:0] v);
    reg_word_t w;
    w = '0;
    w[NCH-1:0] = v;
    return w;
  endfunction

  assign w_set = (w_deb & ~r_deb_q & r_rise) | (~w_deb & r_deb_q & r_fall);
  assign w_wr  = req & we;
  assign w_clr = (w_wr && addr == GPIO_PEND) ? wdata[NCH-1:0] : '0;

  always_comb begin
    w_rd = '0;
    case (addr)
      GPIO_DATA: w_rd = zext(w_deb);
      GPIO_EN:   w_rd = zext(r_en);
      GPIO_RISE: w_rd = zext(r_rise);
      GPIO_FALL: w_rd = zext(r_fall);
      GPIO_PEND: w_rd = zext(r_pend);
      GPIO_STAT: w_rd = zext(r_pend & r_en);
      default:   w_rd = '0;
    endcase
  end

  // Clear is applied before set so an edge landing with a W1C keeps its bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_deb_q <= '0;
      r_en    <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      r_pend  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_deb_q <= w_deb;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      r_irq   <= |(r_pend & r_en);
      r_ack   <= req;
      r_rdata <= (req && !we) ? w_rd : '0;
      if (w_wr) begin
        case (addr)
          GPIO_EN:   r_en   <= wdata[NCH-1:0];
          GPIO_RISE: r_rise <= wdata[NCH-1:0];
          GPIO_FALL: r_fall <= wdata[NCH-1:0];
          default:   ;
        endcase
      end
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign irq   = r_irq;
endmodule

// File: tb/tb_gpio_intc.sv
// Self-checking bench for gpio_intc; expected latencies follow the
// GPIO_INTC_DEBOUNCE_EN build selection.
module tb_gpio_intc;
  import gpio_intc_pkg::*;

  localparam int NCH = 8;
  localparam int D   = 4;
  localparam int S   = 2;
`ifdef GPIO_INTC_DEBOUNCE_EN
  localparam int LAT = S + D;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = S;
  localparam bit DEB = 1'b0;
`endif
  localparam logic [31:0] MASK = (32'h1 << NCH) - 32'h1;

  typedef struct {
    logic        we;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } item_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] gpio_in = '0;
  logic           req = 1'b0;
  logic           we = 1'b0;
  logic [2:0]     addr = '0;
  logic [31:0]    wdata = '0;
  logic [31:0]    rdata;
  logic           ack;
  logic           irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          chk_q[$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  gpio_intc #(
    .NCH(NCH), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .irq(irq)
  );

  always @(negedge clk) if (mon_en && ack) got_q.push_back(rdata);

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d, output logic k);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    d = rdata;
    k = ack;
  endtask

  task automatic apply_reset();
    rst = 1'b0; req = 1'b0; we = 1'b0; gpio_in = '0;
    cyc(3);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, e;
    logic k;
    cyc(3);
    rst = 1'b1;
    bus_wr(GPIO_EN, 32'hFF); bus_wr(GPIO_RISE, 32'hFF); bus_wr(GPIO_FALL, 32'hFF);
    gpio_in = '1;
    cyc(LAT + 4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    apply_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(32'h0);
      bus_rd(3'(a), rd, k);
      e = exp_q.pop_front();
      checks++; if (rd !== e) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", a, rd, e); end
      checks++; if (k !== 1'b1) begin errors++; $display("FAIL reset_ack%0d: got %b want 1", a, k); end
    end
    cyc(1);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_single: got %b want 0", ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after: got %b want 0", irq); end
  endtask

  task automatic test_rise();
    logic [31:0] rd, e;
    logic k;
    apply_reset();
    bus_wr(GPIO_EN, 32'h1); bus_wr(GPIO_RISE, 32'h1);
    gpio_in[0] = 1'b1;
    cyc(LAT + 1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early: got %b want 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq); end
    exp_q.push_back(32'h1);
    bus_rd(GPIO_DATA, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL rise_data: got %h want %h", rd, e); end
    exp_q.push_back(32'h1);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL rise_pend: got %h want %h", rd, e); end
    bus_wr(GPIO_PEND, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold: got %b want 1", irq); end
    cyc(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b want 0", irq); end
    exp_q.push_back(32'h0);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL w1c_pend: got %h want %h", rd, e); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd, e;
    logic k;
    apply_reset();
    bus_wr(GPIO_EN, 32'h8); bus_wr(GPIO_RISE, 32'h8); bus_wr(GPIO_FALL, 32'h8);
    gpio_in[3] = 1'b1;
    cyc(3);
    gpio_in[3] = 1'b0;
    cyc(LAT + 4);
    checks++; if (irq !== !DEB) begin errors++; $display("FAIL glitch_irq: got %b want %b", irq, !DEB); end
    exp_q.push_back(32'h0);
    bus_rd(GPIO_DATA, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL glitch_data: got %h want %h", rd, e); end
    exp_q.push_back(DEB ? 32'h0 : 32'h8);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL glitch_pend: got %h want %h", rd, e); end
    bus_wr(GPIO_PEND, 32'hFF);
    gpio_in[3] = 1'b1;
    cyc(LAT + 3);
    exp_q.push_back(32'h8);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL long_rise_pend: got %h want %h", rd, e); end
    exp_q.push_back(32'h8);
    bus_rd(GPIO_DATA, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL long_data: got %h want %h", rd, e); end
    bus_wr(GPIO_PEND, 32'h8);
    exp_q.push_back(32'h0);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL long_clear: got %h want %h", rd, e); end
    gpio_in[3] = 1'b0;
    cyc(LAT + 3);
    exp_q.push_back(32'h8);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL long_fall_pend: got %h want %h", rd, e); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd, e;
    logic k;
    apply_reset();
    bus_wr(GPIO_RISE, 32'h04); bus_wr(GPIO_FALL, 32'h20);
    gpio_in = 8'h24;
    cyc(LAT + 3);
    exp_q.push_back(32'h04);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL coll_setup: got %h want %h", rd, e); end
    gpio_in[5] = 1'b0;
    cyc(LAT);
    bus_wr(GPIO_PEND, 32'h24);
    exp_q.push_back(32'h20);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL coll_pend: got %h want %h", rd, e); end
  endtask

  task automatic test_masked();
    logic [31:0] rd, e;
    logic k;
    apply_reset();
    bus_wr(GPIO_RISE, 32'h80);
    gpio_in[7] = 1'b1;
    cyc(LAT + 3);
    exp_q.push_back(32'h0);
    bus_rd(GPIO_STAT, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL masked_stat: got %h want %h", rd, e); end
    exp_q.push_back(32'h80);
    bus_rd(GPIO_PEND, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL masked_pend: got %h want %h", rd, e); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq: got %b want 0", irq); end
    bus_wr(GPIO_EN, 32'h80);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL enable_irq_early: got %b want 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL enable_irq: got %b want 1", irq); end
    exp_q.push_back(32'h80);
    bus_rd(GPIO_STAT, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL enable_stat: got %h want %h", rd, e); end
  endtask

  task automatic test_regs();
    logic [31:0] rd, e;
    logic k;
    logic [2:0] ro [4];
    ro = '{GPIO_DATA, GPIO_STAT, 3'd6, 3'd7};
    apply_reset();
    bus_wr(GPIO_EN, 32'hFFFF_FFFF);
    exp_q.push_back(MASK);
    bus_rd(GPIO_EN, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL en_width: got %h want %h", rd, e); end
    bus_wr(GPIO_RISE, 32'hA5A5_A5A5);
    exp_q.push_back(32'hA5A5_A5A5 & MASK);
    bus_rd(GPIO_RISE, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL rise_rw: got %h want %h", rd, e); end
    bus_wr(GPIO_FALL, 32'h5A5A_5A5A);
    exp_q.push_back(32'h5A5A_5A5A & MASK);
    bus_rd(GPIO_FALL, rd, k); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL fall_rw: got %h want %h", rd, e); end
    for (int i = 0; i < 4; i++) begin
      bus_wr(ro[i], 32'hFFFF_FFFF);
      exp_q.push_back(32'h0);
      bus_rd(ro[i], rd, k); e = exp_q.pop_front();
      checks++; if (rd !== e) begin errors++; $display("FAIL ro_reg%0d: got %h want %h", ro[i], rd, e); end
    end
  endtask

  task automatic test_back_to_back();
    item_t it[$];
    logic [31:0] g, e;
    bit c;
    apply_reset();
    it.push_back('{1'b1, GPIO_EN,   32'h11, 32'h0});
    it.push_back('{1'b0, GPIO_EN,   32'h0,  32'h11});
    it.push_back('{1'b1, GPIO_RISE, 32'hA5, 32'h0});
    it.push_back('{1'b1, GPIO_FALL, 32'h5A, 32'h0});
    it.push_back('{1'b0, GPIO_RISE, 32'h0,  32'hA5});
    it.push_back('{1'b0, GPIO_FALL, 32'h0,  32'h5A});
    it.push_back('{1'b0, GPIO_DATA, 32'h0,  32'h0});
    it.push_back('{1'b0, 3'd6,      32'h0,  32'h0});
    it.push_back('{1'b0, GPIO_EN,   32'h0,  32'h11});
    got_q.delete();
    mon_en = 1'b1;
    foreach (it[i]) begin
      req = 1'b1; we = it[i].we; addr = it[i].a; wdata = it[i].d;
      chk_q.push_back(!it[i].we);
      exp_q.push_back(it[i].e);
      @(negedge clk);
    end
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    checks++; if (got_q.size() != it.size()) begin errors++; $display("FAIL b2b_acks: got %0d want %0d", got_q.size(), it.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); c = chk_q.pop_front();
      if (c) begin
        checks++; if (g !== e) begin errors++; $display("FAIL b2b_rdata: got %h want %h", g, e); end
      end
    end
    exp_q.delete(); chk_q.delete();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    gpio_in[0] = 1'b1;
    cyc(LAT - 1);
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    bus_wr(GPIO_RISE, 32'h1);
    bus_wr(GPIO_EN, 32'h1);
    cyc(LAT - 1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq_early: got %b want 0", irq); end
    cyc(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_reset_irq: got %b want 1", irq); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_w1c_collision();
    test_masked();
    test_regs();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
